// File: rtl/ram_port_arbiter_pkg.sv
// Shared client identifiers, default widths and small helpers for the
// two-client RAM port arbiter.
package ram_port_arbiter_pkg;

   localparam int CLIENT0    = 0;
   localparam int CLIENT1    = 1;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   typedef enum logic {
      CLIENT_0 = 1'(CLIENT0),
      CLIENT_1 = 1'(CLIENT1)
   } client_e;

   function automatic logic [1:0] client_onehot(input client_e c);
      return (c == CLIENT_1) ? 2'b10 : 2'b01;
   endfunction

   function automatic client_e other_client(input client_e c);
      return (c == CLIENT_1) ? CLIENT_0 : CLIENT_1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side write/read handshake bundle for ram_port_arbiter.
// Client i occupies slice i of every packed address/data vector.
interface ram_port_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [1:0]          wr_valid;
   logic [2*ADDR_W-1:0] wr_addr;
   logic [2*DATA_W-1:0] wr_data;
   logic [1:0]          wr_ready;
   logic [1:0]          rd_valid;
   logic [2*ADDR_W-1:0] rd_addr;
   logic [1:0]          rd_ready;
   logic [1:0]          rd_rvalid;
   logic [DATA_W-1:0]   rd_rdata;

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      output wr_ready, rd_ready, rd_rvalid, rd_rdata
   );

   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      input  wr_ready, rd_ready, rd_rvalid, rd_rdata
   );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority pointer that
// advances only after the pointer client itself is granted.
module rr_arb2
   import ram_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   client_e ptr_reg;
   client_e ptr_next;

   always_comb begin
      gnt      = 2'b00;
      ptr_next = ptr_reg;
      // Grants are masked while reset is held so no handshake completes then.
      if (rst) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = client_onehot(ptr_reg);
            default: gnt = 2'b00;
         endcase
      end
      if ((gnt & client_onehot(ptr_reg)) != 2'b00) begin
         ptr_next = other_client(ptr_reg);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg <= CLIENT_0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client controller for a 2**ADDR_W x DATA_W dual-port RAM: independent
// round-robin on write and read ports, registered RAM controls, tagged read data.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   ram_port_arbiter_if.slave   bus,
   output logic                ram_we,
   output logic [ADDR_W-1:0]   ram_wr_addr,
   output logic [DATA_W-1:0]   ram_din,
   output logic                ram_re,
   output logic [ADDR_W-1:0]   ram_re_addr,
   input  logic [DATA_W-1:0]   ram_dout
);

   logic [1:0]        wr_gnt;
   logic [1:0]        rd_gnt;
   logic [ADDR_W-1:0] wr_addr_c [2];
   logic [DATA_W-1:0] wr_data_c [2];
   logic [ADDR_W-1:0] rd_addr_c [2];
   client_e           wr_sel;
   client_e           rd_sel;

   logic              ram_we_reg;
   logic [ADDR_W-1:0] ram_wr_addr_reg;
   logic [DATA_W-1:0] ram_din_reg;
   logic              ram_re_reg;
   logic [ADDR_W-1:0] ram_re_addr_reg;
   client_e           rd_client_reg;
   logic [1:0]        rd_rvalid_reg;
   logic [DATA_W-1:0] rd_rdata_reg;
   logic              collision;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_client
         assign wr_addr_c[gi] = bus.wr_addr[gi*ADDR_W +: ADDR_W];
         assign wr_data_c[gi] = bus.wr_data[gi*DATA_W +: DATA_W];
         assign rd_addr_c[gi] = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   rr_arb2 u_wr_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.wr_valid),
      .gnt (wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk (clk),
      .rst (rst),
      .req (bus.rd_valid),
      .gnt (rd_gnt)
   );

   assign wr_sel = wr_gnt[1] ? CLIENT_1 : CLIENT_0;
   assign rd_sel = rd_gnt[1] ? CLIENT_1 : CLIENT_0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_we_reg      <= 1'b0;
         ram_wr_addr_reg <= '0;
         ram_din_reg     <= '0;
      end else begin
         ram_we_reg <= |wr_gnt;
         if (|wr_gnt) begin
            ram_wr_addr_reg <= wr_addr_c[wr_sel];
            ram_din_reg     <= wr_data_c[wr_sel];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_re_reg      <= 1'b0;
         ram_re_addr_reg <= '0;
         rd_client_reg   <= CLIENT_0;
      end else begin
         ram_re_reg <= |rd_gnt;
         if (|rd_gnt) begin
            ram_re_addr_reg <= rd_addr_c[rd_sel];
            rd_client_reg   <= rd_sel;
         end
      end
   end

   // The RAM writes at the same edge we sample d_out, so forward the write data.
   assign collision = ram_we_reg && ram_re_reg && (ram_wr_addr_reg == ram_re_addr_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_rvalid_reg <= 2'b00;
         rd_rdata_reg  <= '0;
      end else begin
         rd_rvalid_reg <= ram_re_reg ? client_onehot(rd_client_reg) : 2'b00;
         if (ram_re_reg) begin
            rd_rdata_reg <= collision ? ram_din_reg : ram_dout;
         end
      end
   end

   assign bus.wr_ready  = wr_gnt;
   assign bus.rd_ready  = rd_gnt;
   assign bus.rd_rvalid = rd_rvalid_reg;
   assign bus.rd_rdata  = rd_rdata_reg;
   assign ram_we        = ram_we_reg;
   assign ram_wr_addr   = ram_wr_addr_reg;
   assign ram_din       = ram_din_reg;
   assign ram_re        = ram_re_reg;
   assign ram_re_addr   = ram_re_addr_reg;

endmodule
